// File: rtl/decode_sb.sv
// RV32I decode stage with operand forwarding and a load-use scoreboard.
// One registered micro-op slot towards execute, valid/ready on both sides.
package decode_sb_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000, CMP_NE  = 3'b001,
        CMP_LT  = 3'b100, CMP_GE  = 3'b101,
        CMP_LTU = 3'b110, CMP_GEU = 3'b111
    } cmp_op_e;

    typedef enum logic [1:0] {EX_ALU, EX_PC4, EX_MEM} ex_sel_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_v;
        logic [XLEN-1:0] rs2_v;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd_s;
        logic            rd_we;
        alu_op_e         alu_op;
        cmp_op_e         cmp_op;
        logic            alu_sel_a_pc;
        logic            alu_sel_b_imm;
        ex_sel_e         ex_mux_sel;
        logic [2:0]      funct3;
        logic            is_load;
        logic            is_store;
        logic            is_jump;
        logic            is_jump_conditional;
    } id_ex_t;
endpackage

module decode_sb
    import decode_sb_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             in_instr_i,
    input  logic [XLEN-1:0]         in_pc_i,
    output logic [4:0]              rs1_s_o,
    output logic [4:0]              rs2_s_o,
    input  logic [XLEN-1:0]         rs1_v_i,
    input  logic [XLEN-1:0]         rs2_v_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD*5-1:0]    fwd_rd_s_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_rd_v_i,
    input  logic                    ld_done_i,
    input  logic [4:0]              ld_done_rd_i,
    output id_ex_t                  out_o,
    input  logic                    out_ready_i,
    output logic [CNT_W-1:0]        stall_cnt_o
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        is_lui, is_auipc, is_jal, is_jalr;
    logic        is_br, is_ld, is_st, is_opi, is_op;
    logic        rs1_used, rs2_used;
    logic        hz1, hz2, hazard, space, cap;
    logic [31:1] pending_q;
    logic [31:0] pend_w, set_v, clr_v;
    logic [CNT_W-1:0] stall_q;
    id_ex_t      d, out_q;

    assign opc = in_instr_i[6:0];
    assign f3  = in_instr_i[14:12];
    assign rs1 = in_instr_i[19:15];
    assign rs2 = in_instr_i[24:20];
    assign rd  = in_instr_i[11:7];

    assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25],
                    in_instr_i[11:7]};
    assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                    in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    assign imm_u = {in_instr_i[31:12], 12'b0};
    assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31],
                    in_instr_i[19:12], in_instr_i[20],
                    in_instr_i[30:21], 1'b0};

    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_br    = opc == OPC_BRANCH;
    assign is_ld    = opc == OPC_LOAD;
    assign is_st    = opc == OPC_STORE;
    assign is_opi   = opc == OPC_OP_IMM;
    assign is_op    = opc == OPC_OP;

    // Reverse scan so the lowest-index (youngest) matching port wins.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0] rs, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] v;
        v = rf;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid_i[i] && rs != 5'd0 &&
                fwd_rd_s_i[i*5 +: 5] == rs)
                v = fwd_rd_v_i[i*XLEN +: XLEN];
        end
        if (rs == 5'd0) v = '0;
        return v;
    endfunction

    function automatic alu_op_e alu_dec(
        input logic [2:0] fn, input logic alt);
        alu_op_e a;
        unique case (fn)
            3'b000:  a = alt ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = alt ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    always_comb begin
        d          = '0;
        d.valid    = 1'b1;
        d.pc       = in_pc_i;
        d.rd_s     = rd;
        d.funct3   = f3;
        d.rs1_v    = fwd_sel(rs1, rs1_v_i);
        d.rs2_v    = fwd_sel(rs2, rs2_v_i);
        rs1_used   = 1'b1;
        rs2_used   = 1'b0;
        unique case (1'b1)
            is_lui: begin
                d.imm = imm_u; d.alu_op = ALU_PASS_B;
                d.alu_sel_b_imm = 1'b1; d.rd_we = 1'b1;
                rs1_used = 1'b0;
            end
            is_auipc: begin
                d.imm = imm_u; d.alu_sel_a_pc = 1'b1;
                d.alu_sel_b_imm = 1'b1; d.rd_we = 1'b1;
                rs1_used = 1'b0;
            end
            is_jal: begin
                d.imm = imm_j; d.alu_sel_a_pc = 1'b1;
                d.alu_sel_b_imm = 1'b1; d.ex_mux_sel = EX_PC4;
                d.rd_we = 1'b1; d.is_jump = 1'b1;
                rs1_used = 1'b0;
            end
            is_jalr: begin
                d.imm = imm_i; d.alu_sel_b_imm = 1'b1;
                d.ex_mux_sel = EX_PC4; d.rd_we = 1'b1;
                d.is_jump = 1'b1;
            end
            is_br: begin
                d.imm = imm_b; d.alu_sel_a_pc = 1'b1;
                d.alu_sel_b_imm = 1'b1; d.cmp_op = cmp_op_e'(f3);
                d.is_jump_conditional = 1'b1; rs2_used = 1'b1;
            end
            is_ld: begin
                d.imm = imm_i; d.alu_sel_b_imm = 1'b1;
                d.ex_mux_sel = EX_MEM; d.rd_we = 1'b1;
                d.is_load = 1'b1;
            end
            is_st: begin
                d.imm = imm_s; d.alu_sel_b_imm = 1'b1;
                d.is_store = 1'b1; rs2_used = 1'b1;
            end
            is_opi: begin
                d.imm = imm_i; d.alu_sel_b_imm = 1'b1;
                d.alu_op = alu_dec(f3, f3 == 3'b101 && in_instr_i[30]);
                d.rd_we = 1'b1;
            end
            is_op: begin
                d.alu_op = alu_dec(f3, in_instr_i[30]);
                d.rd_we = 1'b1; rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    // A load finishing this cycle no longer blocks its consumer.
    assign pend_w = {pending_q, 1'b0};
    assign hz1 = rs1_used && pend_w[rs1] &&
                 !(ld_done_i && ld_done_rd_i == rs1);
    assign hz2 = rs2_used && pend_w[rs2] &&
                 !(ld_done_i && ld_done_rd_i == rs2);
    assign hazard = in_valid_i && (hz1 || hz2);
    assign space  = !out_q.valid || out_ready_i;

    assign in_ready_o = flush_i || (space && !hazard);
    assign cap        = in_valid_i && in_ready_o && !flush_i;

    assign clr_v = ld_done_i ? (32'd1 << ld_done_rd_i) : 32'd0;
    assign set_v = (cap && d.is_load) ? (32'd1 << rd) : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q     <= '0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            if (flush_i)          out_q.valid <= 1'b0;
            else if (cap)         out_q       <= d;
            else if (out_ready_i) out_q.valid <= 1'b0;
            pending_q <= (pending_q & ~clr_v[31:1]) | set_v[31:1];
            if (hazard && !flush_i && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign rs1_s_o     = rs1;
    assign rs2_s_o     = rs2;
    assign out_o       = out_q;
    assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_decode_sb.sv
// Bench for decode_sb: directed scenarios then random traffic
// against a behavioural decode/scoreboard model.
module tb_decode_sb;
    import decode_sb_pkg::*;

    localparam int NF = 2;
    localparam int CW = 4;

    logic            clk, rst_ni, flush_i;
    logic            in_valid_i, in_ready_o;
    logic [31:0]     in_instr_i, in_pc_i;
    logic [4:0]      rs1_s_o, rs2_s_o;
    logic [31:0]     rs1_v_i, rs2_v_i;
    logic [NF-1:0]   fwd_valid_i;
    logic [NF*5-1:0] fwd_rd_s_i;
    logic [NF*32-1:0] fwd_rd_v_i;
    logic            ld_done_i;
    logic [4:0]      ld_done_rd_i;
    id_ex_t          out_o;
    logic            out_ready_i;
    logic [CW-1:0]   stall_cnt_o;

    int checks = 0;
    int failures = 0;

    bit [31:0] m_pend;
    int        m_cnt;
    logic      m_valid;
    logic [31:0] m_pc, m_imm, m_rs1v, m_rs2v;
    logic [9:0]  m_ctrl;

    decode_sb #(.NUM_FWD(NF), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .rs1_s_o(rs1_s_o), .rs2_s_o(rs2_s_o),
        .rs1_v_i(rs1_v_i), .rs2_v_i(rs2_v_i),
        .fwd_valid_i(fwd_valid_i), .fwd_rd_s_i(fwd_rd_s_i),
        .fwd_rd_v_i(fwd_rd_v_i),
        .ld_done_i(ld_done_i), .ld_done_rd_i(ld_done_rd_i),
        .out_o(out_o), .out_ready_i(out_ready_i),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v,
                                         input int bits);
        if (((v >> (bits - 1)) & 32'd1) != 0)
            return v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] x);
        logic [6:0] op;
        op = x[6:0];
        if (op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_JALR)
            return sext(x >> 20, 12);
        if (op == OPC_STORE)
            return sext(((x >> 25) << 5) | ((x >> 7) & 31), 12);
        if (op == OPC_BRANCH)
            return sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
                        | (((x >> 25) & 63) << 5)
                        | (((x >> 8) & 15) << 1), 13);
        if (op == OPC_LUI || op == OPC_AUIPC)
            return x & 32'hFFFF_F000;
        if (op == OPC_JAL)
            return sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12)
                        | (((x >> 20) & 1) << 11)
                        | (((x >> 21) & 1023) << 1), 21);
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] rs,
                                          input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        for (int i = 0; i < NF; i++)
            if (fwd_valid_i[i] && fwd_rd_s_i[i*5 +: 5] == rs)
                return fwd_rd_v_i[i*32 +: 32];
        return rf;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_OP ||
               op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL ||
               op == OPC_JALR;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_cnt = 0; m_valid = 1'b0;
        m_pc = '0; m_imm = '0; m_rs1v = '0; m_rs2v = '0; m_ctrl = '0;
    endtask

    task automatic set_fwd(input int p, input logic v,
                           input logic [4:0] rd, input logic [31:0] val);
        fwd_valid_i[p] = v;
        fwd_rd_s_i[p*5 +: 5] = rd;
        fwd_rd_v_i[p*32 +: 32] = val;
    endtask

    task automatic clr_side();
        fwd_valid_i = '0; fwd_rd_s_i = '0; fwd_rd_v_i = '0;
        ld_done_i = 1'b0; ld_done_rd_i = '0; flush_i = 1'b0;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins,
                          input logic [31:0] pc);
        in_valid_i = v; in_instr_i = ins; in_pc_i = pc;
    endtask

    // One clock: combinational checks before the edge, registered after.
    task automatic step();
        logic [6:0] op;
        logic [4:0] r1, r2, rd;
        logic u1, u2, hz, rdy, cap;
        #3;
        op = in_instr_i[6:0];
        r1 = in_instr_i[19:15];
        r2 = in_instr_i[24:20];
        rd = in_instr_i[11:7];
        u1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
        u2 = op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
        hz = in_valid_i &&
             ((u1 && m_pend[r1] && !(ld_done_i && ld_done_rd_i == r1)) ||
              (u2 && m_pend[r2] && !(ld_done_i && ld_done_rd_i == r2)));
        rdy = flush_i || ((!m_valid || out_ready_i) && !hz);
        cap = in_valid_i && rdy && !flush_i;
        chk("in_ready", in_ready_o, rdy);
        chk("rs1_s", rs1_s_o, r1);
        chk("rs2_s", rs2_s_o, r2);
        if (ld_done_i && ld_done_rd_i != 0) m_pend[ld_done_rd_i] = 1'b0;
        if (cap && op == OPC_LOAD && rd != 0) m_pend[rd] = 1'b1;
        if (hz && !flush_i && m_cnt < 15) m_cnt++;
        if (flush_i) m_valid = 1'b0;
        else if (cap) begin
            m_valid = 1'b1;
            m_pc = in_pc_i;
            m_imm = imm_of(in_instr_i);
            m_rs1v = m_fwd(r1, rs1_v_i);
            m_rs2v = m_fwd(r2, rs2_v_i);
            m_ctrl = {rd, writes_rd(op), op == OPC_LOAD, op == OPC_STORE,
                      op == OPC_JAL || op == OPC_JALR, op == OPC_BRANCH};
        end else if (out_ready_i) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", out_o.valid, m_valid);
        chk("out_pc", out_o.pc, m_pc);
        chk("out_imm", out_o.imm, m_imm);
        chk("out_rs1_v", out_o.rs1_v, m_rs1v);
        chk("out_rs2_v", out_o.rs2_v, m_rs2v);
        chk("out_ctrl", {out_o.rd_s, out_o.rd_we, out_o.is_load,
            out_o.is_store, out_o.is_jump, out_o.is_jump_conditional},
            m_ctrl);
        chk("stall_cnt", stall_cnt_o, m_cnt);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] x;
        ops = '{OPC_OP_IMM, OPC_LOAD, OPC_OP, OPC_STORE, OPC_BRANCH,
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, 7'h7f};
        x = $urandom;
        x[6:0]   = ops[$urandom_range(0, 9)];
        x[11:7]  = 5'($urandom_range(0, 7));
        x[19:15] = 5'($urandom_range(0, 7));
        x[24:20] = 5'($urandom_range(0, 7));
        return x;
    endfunction

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] LW_X3      = 32'h0000_A183;
    localparam logic [31:0] LW_X7      = 32'h0000_A383;
    localparam logic [31:0] ADD_X4_X3  = 32'h0021_8233;
    localparam logic [31:0] ADDI_X6_X5 = 32'h0002_8313;
    localparam logic [31:0] ADD_X8_X7  = 32'h0003_8433;

    initial begin
        rst_ni = 1'b0;
        clr_side();
        set_in(1'b0, 32'd0, 32'd0);
        rs1_v_i = 32'hDEAD_0001; rs2_v_i = 32'hDEAD_0002;
        out_ready_i = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", out_o.valid, 1'b0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_ready", in_ready_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        step();

        set_in(1'b1, ADDI_X1_5, 32'h100);
        step();
        chk("addi_valid", out_o.valid, 1'b1);
        chk("addi_imm", out_o.imm, 32'd5);
        chk("addi_rd", out_o.rd_s, 5'd1);
        chk("addi_we", out_o.rd_we, 1'b1);
        chk("addi_bimm", out_o.alu_sel_b_imm, 1'b1);

        set_in(1'b1, LW_X3, 32'h104);
        step();
        set_in(1'b1, ADD_X4_X3, 32'h108);
        repeat (3) step();
        chk("lu_stall3", stall_cnt_o, 4'd3);
        ld_done_i = 1'b1; ld_done_rd_i = 5'd3;
        set_fwd(1, 1'b1, 5'd3, 32'hAB);
        step();
        chk("lu_cap_pc", out_o.pc, 32'h108);
        chk("lu_rs1_v", out_o.rs1_v, 32'hAB);
        clr_side();
        set_in(1'b1, ADD_X4_X3, 32'h10C);
        step();
        chk("lu_p3_clear", out_o.pc, 32'h10C);

        set_in(1'b1, ADDI_X6_X5, 32'h110);
        set_fwd(0, 1'b1, 5'd5, 32'h11);
        set_fwd(1, 1'b1, 5'd5, 32'h22);
        step();
        chk("fwd_prio", out_o.rs1_v, 32'h11);
        clr_side();

        out_ready_i = 1'b0;
        set_in(1'b1, ADDI_X1_5, 32'h114);
        repeat (3) step();
        chk("bp_hold_pc", out_o.pc, 32'h110);
        chk("bp_hold_v", out_o.rs1_v, 32'h11);
        out_ready_i = 1'b1;
        step();
        chk("bp_release", out_o.pc, 32'h114);

        set_in(1'b1, LW_X3, 32'h118);
        step();
        flush_i = 1'b1;
        set_in(1'b1, LW_X7, 32'h11C);
        step();
        chk("flush_valid", out_o.valid, 1'b0);
        flush_i = 1'b0;
        set_in(1'b1, ADD_X8_X7, 32'h120);
        step();
        chk("flush_p7", out_o.rd_s, 5'd8);
        set_in(1'b1, ADD_X4_X3, 32'h124);
        repeat (6) step();
        chk("flush_p3_kept", stall_cnt_o, 4'd9);

        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", out_o.valid, 1'b0);
        chk("mid_rst_stall", stall_cnt_o, 4'd0);
        chk("mid_rst_ready", in_ready_o, 1'b1);
        model_reset();
        #1;
        rst_ni = 1'b1;
        step();
        chk("rst_p3_clear", out_o.pc, 32'h124);

        set_in(1'b1, LW_X3, 32'h128);
        step();
        set_in(1'b1, ADD_X4_X3, 32'h12C);
        repeat (20) step();
        chk("sat_15", stall_cnt_o, 4'd15);
        ld_done_i = 1'b1; ld_done_rd_i = 5'd3;
        set_fwd(0, 1'b1, 5'd3, 32'h33);
        step();
        clr_side();

        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 9) < 8, rand_instr(),
                   $urandom & 32'hFFFF_FFFC);
            rs1_v_i = $urandom; rs2_v_i = $urandom;
            for (int p = 0; p < NF; p++)
                set_fwd(p, 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 7)), $urandom);
            ld_done_i = $urandom_range(0, 3) == 0;
            ld_done_rd_i = 5'($urandom_range(0, 7));
            out_ready_i = $urandom_range(0, 9) < 7;
            flush_i = $urandom_range(0, 19) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_sb.md
DECODE_SB -- requirements
Module: decode_sb

Interface
REQ-001 SHALL have parameter NUM_FWD, default 2, giving the number of forwarding ports; port 0 has the highest priority (youngest).
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the stall counter.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  kills the instruction in the output register and the instruction at the input.
REQ-006 in_valid_i / in_ready_o  input/output  1/1  fetch-side handshake.
REQ-007 in_instr_i / in_pc_i  input  32/XLEN  instruction and its PC.
REQ-008 rs1_s_o / rs2_s_o  output  5/5  register-file read addresses, driven from in_instr_i[19:15] / [24:20].
REQ-009 rs1_v_i / rs2_v_i  input  XLEN/XLEN  register-file read data, available in the same cycle.
REQ-010 fwd_valid_i / fwd_rd_s_i / fwd_rd_v_i  input  NUM_FWD/NUM_FWD*5/NUM_FWD*XLEN  forwarding sources.
REQ-011 ld_done_i / ld_done_rd_i  input  1/5  load result is written back this cycle; its data is also on a fwd port.
REQ-012 out_o  output  id_ex_t  registered decoded micro-op; out_o.valid is the output valid.
REQ-013 out_ready_i  input  1  execute stage accepts out_o.
REQ-014 stall_cnt_o  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-015 Decode SHALL follow the Orion RV32I table: opcode, funct3, funct7 and the I/S/B/U/J immediates map to alu_op, cmp_op, selects, ex_mux_sel, imm, rd_we, is_load, is_store, is_jump and is_jump_conditional.
REQ-016 Unknown opcodes SHALL decode as a NOP: rd_we=0, is_load=0, is_store=0, is_jump=0.
REQ-017 rs1 SHALL be treated as used for all opcodes except LUI, AUIPC and JAL.
REQ-018 rs2 SHALL be treated as used only for OP_REG, STORE and BRANCH.
REQ-019 Forwarded value per operand = the lowest-index fwd port with fwd_valid_i=1, fwd_rd_s_i != 0 and rd equal to the source register; else rs*_v_i. Register x0 always reads 0.
REQ-020 Scoreboard: pending[31:1] flops; x0 is never pending.
REQ-021 pending[rd] SHALL set when a load with rd != 0 is captured into the output register.
REQ-022 pending[rd] SHALL clear on ld_done_i with ld_done_rd_i=rd.
REQ-023 When the set and the clear of pending[rd] occur in the same cycle, set SHALL win.
REQ-024 hazard = a used operand rs has pending[rs]=1 and NOT (ld_done_i && ld_done_rd_i==rs).
REQ-025 space = !out_o.valid || out_ready_i.
REQ-026 in_ready_o SHALL equal flush_i || (space && !hazard).
REQ-027 Capture: on in_valid_i && in_ready_o && !flush_i, the output register loads the decoded micro-op with valid=1. Latency is exactly 1 cycle.
REQ-028 If out_o.valid && out_ready_i and nothing is captured, out_o.valid SHALL drop to 0 next cycle.
REQ-029 While out_o.valid && !out_ready_i, out_o SHALL hold all fields stable.
REQ-030 Flush: next cycle out_o.valid=0, and the input instruction is consumed without capture and without a scoreboard update.
REQ-031 Flush: existing pending bits are kept, because older loads still complete.
REQ-032 stall_cnt_o SHALL increment once per cycle with in_valid_i && hazard && !flush_i, saturating at all-ones.
REQ-033 Hazard SHALL be evaluated only while in_valid_i=1.
REQ-034 in_ready_o SHALL be independent of out_o field values.

Reset
REQ-035 On rst_ni low, asynchronously: out_o.valid=0, all other out_o fields 0, pending=0, stall_cnt_o=0.
REQ-036 in_ready_o SHALL equal 1 during reset, since space=1 and there is no hazard.
REQ-037 Reset deassertion SHALL be synchronised externally; the block makes no capture in the cycle of deassertion if in_valid_i=0.

Verification
REQ-038 ADDI x1,x0,5 with out_ready_i=1 -> one cycle later out_o.valid=1, imm=5, rd_s=1, rd_we=1, alu_sel_b_imm=1.
REQ-039 LW x3 accepted, then ADD x4,x3,x2 -> in_ready_o=0 and stall_cnt_o increments each cycle; ld_done_i with rd=3 and fwd port 1 carrying x3=0xAB -> ADD captured that cycle with rs1_v=0xAB, pending[3]=0.
REQ-040 fwd port 0 rd=5 value 0x11 and port 1 rd=5 value 0x22, both valid -> rs1_v=0x11.
REQ-041 out_ready_i=0 for 3 cycles with out_o.valid=1 -> out_o is unchanged and in_ready_o=0; out_ready_i=1 -> the next instruction is captured on the following edge.
REQ-042 LW x7 at the input with flush_i=1 -> out_o.valid=0 next cycle and pending[7] stays 0; a pending[3] already set survives the flush.
REQ-043 rst_ni pulsed low mid-stall with pending[3]=1 and stall_cnt_o=9 -> immediately out_o.valid=0, pending=0, stall_cnt_o=0; saturation test with CNT_W=4 -> the counter stops at 15.
